cordic_share_arb: RTL and testbench
===================================

Name: cordic_share_arb

Overview:
- Shares one vectoring CORDIC and one rotation CORDIC between NREQ ICA requesters, e.g. the weight-update engine and the orthogonalisation engine.
- A requester wins a session, which is exclusive ownership of both units. It drives the units through registered muxes and gets owner-gated result valids. The session is released only after all in-flight operations have drained.
- Sits between the ICA stage controllers and the shared CORDIC instances.

Parameters:
- NREQ, 2, number of requesters (2..4).
- DATA_WIDTH, 16, CORDIC x/y data width.
- OUTST_W, 5, width of each outstanding-operation counter; maximum in flight is 2^OUTST_W-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req  in  NREQ  per-requester session request, level; bit i is requester i.
- gnt  out  NREQ  one-hot session grant.
- vec_en  in  NREQ  per-requester vectoring start pulse.
- vec_xin  in  NREQ*DATA_WIDTH  vectoring x operand, slice i.
- vec_yin  in  NREQ*DATA_WIDTH  vectoring y operand, slice i.
- vec_angle_calc_en  in  NREQ  vectoring angle-calculation enable.
- rot_en  in  NREQ  rotation start pulse.
- rot_xin  in  NREQ*DATA_WIDTH  rotation x operand.
- rot_yin  in  NREQ*DATA_WIDTH  rotation y operand.
- rot_quad_in  in  NREQ*2  rotation quadrant.
- cordic_vec_en  out  1  to the vectoring unit.
- cordic_vec_xin  out  DATA_WIDTH  to the vectoring unit.
- cordic_vec_yin  out  DATA_WIDTH  to the vectoring unit.
- cordic_vec_angle_calc_en  out  1  to the vectoring unit.
- cordic_vec_opvld  in  1  vectoring result valid.
- cordic_rot_en  out  1  to the rotation unit.
- cordic_rot_xin  out  DATA_WIDTH  to the rotation unit.
- cordic_rot_yin  out  DATA_WIDTH  to the rotation unit.
- cordic_rot_quad_in  out  2  to the rotation unit.
- cordic_rot_opvld  in  1  rotation result valid.
- vec_vld  out  NREQ  cordic_vec_opvld routed to the owner only.
- rot_vld  out  NREQ  cordic_rot_opvld routed to the owner only.
- busy  out  1  a session is active or draining.
- err_drop  out  1  one-cycle pulse when a non-owner en is ignored, or an en arrives while draining.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All outputs go to 0.
  - State goes to IDLE, outstanding counters to 0, round-robin pointer to 0.
  - Reset mid-session abandons any in-flight results. Results returning in later cycles are dropped, and vec_vld/rot_vld stay 0 because no owner exists.
- State IDLE:
  - If req is non-zero, pick the first set bit scanning from the pointer with wrap-around: ptr, ptr+1, …, NREQ-1, 0, ….
  - The winner is registered as owner, gnt goes one-hot on the next cycle, state goes to OWN.
  - Grant latency is 1 cycle from req.
- State OWN:
  - Each cycle, the owner's vec_* and rot_* fields are registered onto the cordic_* outputs. Issue latency is 1 cycle.
  - cordic_vec_en and cordic_rot_en are single-cycle pulses, 0 unless the owner's en was high the previous cycle.
  - Operand registers hold their last value when en is low.
  - Each vectoring counter increments on an issued vector en and decrements on cordic_vec_opvld. The rotation counter does the same with rotation en and cordic_rot_opvld.
  - If an issue and a completion occur in the same cycle, the counter is unchanged.
  - vec_vld[owner]=cordic_vec_opvld and rot_vld[owner]=cordic_rot_opvld, combinational pass-through. All other bits are 0.
  - When req[owner] falls:
    - If both counters are 0, go straight to IDLE.
    - Otherwise go to DRAIN.
- State DRAIN:
  - gnt stays asserted and valids are still routed to the owner.
  - New en from any requester is ignored and pulses err_drop.
  - When both counters reach 0, including a same-cycle last completion, go to IDLE.
  - If req[owner] re-rises while in DRAIN, the owner does not regain the session; it competes again in IDLE.
- Leaving a session:
  - gnt clears in the cycle the state enters IDLE.
  - ptr=owner+1 mod NREQ.
  - A new grant cannot occur in that same cycle; the minimum gap between sessions is 1 idle cycle.
- Counter saturation:
  - An issue at the maximum count is still forwarded, and the counter holds at max.
  - An opvld at 0 count is routed but does not decrement, so no underflow.
- busy = state != IDLE.
- Non-owner en in OWN: ignored, err_drop pulses.

Decomposition:
- Shared package ica_pkg holds:
  - the state enum (IDLE, OWN, DRAIN);
  - constants for the CORDIC operand width;
  - a helper function for the round-robin first-set search.
- One natural sub-module: rr_pick, a combinational rotate / priority-encode / unrotate over NREQ bits. It is reusable by other arbiters in the design.

Test Plan:
- Single requester, NREQ=2:
  - Stimulus: req=01. Issue vec_en with xin=0x0400, yin=0x0300. Return opvld 16 cycles later.
  - Required response: gnt=01 one cycle after req. cordic_vec_xin=0x0400 one cycle after vec_en. vec_vld=01. Drop req → IDLE one cycle after, ptr=1.
- Simultaneous requests:
  - Stimulus: req=11 from reset.
  - Required response: requester 0 is granted first. After its release, requester 1 is granted with a 1-cycle gap. A third round with req=11 grants requester 0 again.
- Drain:
  - Stimulus: owner issues 3 rot_en, then drops req before any rotation completes.
  - Required response: state is DRAIN, busy=1, gnt held. The third cordic_rot_opvld returns to IDLE.
- Intrusion:
  - Stimulus: while requester 0 owns the units, requester 1 pulses vec_en.
  - Required response: cordic_vec_en stays 0, err_drop=1 for one cycle, vec_vld=00 throughout.
- Same-cycle issue and completion:
  - Stimulus: owner issues vec_en in the same cycle cordic_vec_opvld arrives, with count=1.
  - Required response: count stays 1. Dropping req afterwards enters DRAIN, not IDLE.
- Reset mid-session:
  - Stimulus: assert rst during DRAIN with 2 operations outstanding.
  - Required response: all outputs 0 next cycle. A late cordic_rot_opvld produces rot_vld=00.

Source files
------------

// File: rtl/ica_pkg.sv
// Shared types and helpers for the ICA CORDIC sharing logic.
// Holds the arbiter state encoding and the round-robin first-set search.
package ica_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  localparam int CORDIC_DW = 16;
  localparam int MAX_REQ   = 4;

  // Index of the first set bit at or after ptr, wrapping within the low n bits.
  function automatic logic [1:0] rr_first(input logic [MAX_REQ-1:0] req,
                                          input logic [1:0]         ptr,
                                          input int                 n);
    logic [1:0] idx;
    logic [1:0] c;
    logic       found;
    idx   = 2'd0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      c = 2'((int'(ptr) + k) % n);
      if (k < n && !found && req[c]) begin
        found = 1'b1;
        idx   = c;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate by ptr, priority-encode, unrotate.
// Zero latency; vld is simply any request present.
module rr_pick import ica_pkg::*; #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          vld,
  output logic [PW-1:0] idx
);

  logic [MAX_REQ-1:0] req_ext;
  logic [1:0]         ptr_ext;
  logic [1:0]         pick;

  always_comb begin
    req_ext = MAX_REQ'(req);
    ptr_ext = 2'(ptr);
    pick    = rr_first(req_ext, ptr_ext, N);
    vld     = |req;
    idx     = PW'(pick);
  end

endmodule

// File: rtl/cordic_share_arb.sv
// Session arbiter sharing one vectoring and one rotation CORDIC; grant and issue take 1 cycle.
// No backpressure: non-owner or draining starts are dropped and flagged on err_drop.
module cordic_share_arb import ica_pkg::*; #(
  parameter int NREQ       = 2,
  parameter int DATA_WIDTH = CORDIC_DW,
  parameter int OUTST_W    = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  output logic [NREQ-1:0]            gnt,
  input  logic [NREQ-1:0]            vec_en,
  input  logic [NREQ*DATA_WIDTH-1:0] vec_xin,
  input  logic [NREQ*DATA_WIDTH-1:0] vec_yin,
  input  logic [NREQ-1:0]            vec_angle_calc_en,
  input  logic [NREQ-1:0]            rot_en,
  input  logic [NREQ*DATA_WIDTH-1:0] rot_xin,
  input  logic [NREQ*DATA_WIDTH-1:0] rot_yin,
  input  logic [NREQ*2-1:0]          rot_quad_in,
  output logic                       cordic_vec_en,
  output logic [DATA_WIDTH-1:0]      cordic_vec_xin,
  output logic [DATA_WIDTH-1:0]      cordic_vec_yin,
  output logic                       cordic_vec_angle_calc_en,
  input  logic                       cordic_vec_opvld,
  output logic                       cordic_rot_en,
  output logic [DATA_WIDTH-1:0]      cordic_rot_xin,
  output logic [DATA_WIDTH-1:0]      cordic_rot_yin,
  output logic [1:0]                 cordic_rot_quad_in,
  input  logic                       cordic_rot_opvld,
  output logic [NREQ-1:0]            vec_vld,
  output logic [NREQ-1:0]            rot_vld,
  output logic                       busy,
  output logic                       err_drop
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [OUTST_W-1:0] CNT_MAX = '1;

  arb_state_t         state;
  logic [PTR_W-1:0]   owner, ptr, pick_idx, owner_inc;
  logic               pick_vld;
  logic [OUTST_W-1:0] vcnt, rcnt, vcnt_nxt, rcnt_nxt;
  logic               own_st, vec_issue, rot_issue, vec_done, rot_done;
  logic               drained, drop_now;

  logic [DATA_WIDTH-1:0] vx [NREQ];
  logic [DATA_WIDTH-1:0] vy [NREQ];
  logic [DATA_WIDTH-1:0] rx [NREQ];
  logic [DATA_WIDTH-1:0] ry [NREQ];
  logic [1:0]            rq [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign vx[i] = vec_xin[i*DATA_WIDTH +: DATA_WIDTH];
    assign vy[i] = vec_yin[i*DATA_WIDTH +: DATA_WIDTH];
    assign rx[i] = rot_xin[i*DATA_WIDTH +: DATA_WIDTH];
    assign ry[i] = rot_yin[i*DATA_WIDTH +: DATA_WIDTH];
    assign rq[i] = rot_quad_in[2*i +: 2];
  end

  rr_pick #(.N(NREQ), .PW(PTR_W)) u_pick (
    .req (req),
    .ptr (ptr),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  assign own_st    = (state == ST_OWN);
  assign vec_issue = own_st && vec_en[owner];
  assign rot_issue = own_st && rot_en[owner];
  // A completion with nothing outstanding is a stray result: routed, not counted.
  assign vec_done  = cordic_vec_opvld && (vcnt != '0);
  assign rot_done  = cordic_rot_opvld && (rcnt != '0);

  always_comb begin
    vcnt_nxt = vcnt;
    if (vec_issue && !vec_done && vcnt != CNT_MAX) vcnt_nxt = vcnt + OUTST_W'(1);
    else if (!vec_issue && vec_done)               vcnt_nxt = vcnt - OUTST_W'(1);
    rcnt_nxt = rcnt;
    if (rot_issue && !rot_done && rcnt != CNT_MAX) rcnt_nxt = rcnt + OUTST_W'(1);
    else if (!rot_issue && rot_done)               rcnt_nxt = rcnt - OUTST_W'(1);
  end

  assign drained   = (vcnt_nxt == '0) && (rcnt_nxt == '0);
  assign owner_inc = (owner == PTR_W'(NREQ - 1)) ? '0 : owner + PTR_W'(1);
  assign drop_now  = (own_st && |((vec_en | rot_en) & ~gnt)) ||
                     ((state == ST_DRAIN) && |(vec_en | rot_en));

  assign vec_vld = gnt & {NREQ{cordic_vec_opvld}};
  assign rot_vld = gnt & {NREQ{cordic_rot_opvld}};
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state                    <= ST_IDLE;
      owner                    <= '0;
      ptr                      <= '0;
      gnt                      <= '0;
      vcnt                     <= '0;
      rcnt                     <= '0;
      err_drop                 <= 1'b0;
      cordic_vec_en            <= 1'b0;
      cordic_vec_xin           <= '0;
      cordic_vec_yin           <= '0;
      cordic_vec_angle_calc_en <= 1'b0;
      cordic_rot_en            <= 1'b0;
      cordic_rot_xin           <= '0;
      cordic_rot_yin           <= '0;
      cordic_rot_quad_in       <= '0;
    end else begin
      vcnt                     <= vcnt_nxt;
      rcnt                     <= rcnt_nxt;
      err_drop                 <= drop_now;
      cordic_vec_en            <= vec_issue;
      cordic_rot_en            <= rot_issue;
      cordic_vec_angle_calc_en <= own_st && vec_angle_calc_en[owner];
      if (vec_issue) begin
        cordic_vec_xin <= vx[owner];
        cordic_vec_yin <= vy[owner];
      end
      if (rot_issue) begin
        cordic_rot_xin     <= rx[owner];
        cordic_rot_yin     <= ry[owner];
        cordic_rot_quad_in <= rq[owner];
      end
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            owner <= pick_idx;
            gnt   <= NREQ'(1) << pick_idx;
            state <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (!req[owner]) begin
            if (drained) begin
              state <= ST_IDLE;
              gnt   <= '0;
              ptr   <= owner_inc;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // req[owner] is ignored here; a re-raise competes again once IDLE.
          if (drained) begin
            state <= ST_IDLE;
            gnt   <= '0;
            ptr   <= owner_inc;
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_share_arb.sv
// Self-checking bench for cordic_share_arb (NREQ=2): scenario tasks plus an issue scoreboard.
module tb_cordic_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, gnt, vec_en, vec_angle_calc_en, rot_en, vec_vld, rot_vld;
  logic [31:0] vec_xin, vec_yin, rot_xin, rot_yin;
  logic [3:0]  rot_quad_in;
  logic        cordic_vec_en, cordic_vec_angle_calc_en, cordic_vec_opvld;
  logic        cordic_rot_en, cordic_rot_opvld, busy, err_drop;
  logic [15:0] cordic_vec_xin, cordic_vec_yin, cordic_rot_xin, cordic_rot_yin;
  logic [1:0]  cordic_rot_quad_in;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] vec_q[$];
  logic [33:0] rot_q[$];
  logic [31:0] vexp;
  logic [33:0] rexp;

  always #5 clk = ~clk;

  cordic_share_arb #(.NREQ(2), .DATA_WIDTH(16), .OUTST_W(5)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .req                      (req),
    .gnt                      (gnt),
    .vec_en                   (vec_en),
    .vec_xin                  (vec_xin),
    .vec_yin                  (vec_yin),
    .vec_angle_calc_en        (vec_angle_calc_en),
    .rot_en                   (rot_en),
    .rot_xin                  (rot_xin),
    .rot_yin                  (rot_yin),
    .rot_quad_in              (rot_quad_in),
    .cordic_vec_en            (cordic_vec_en),
    .cordic_vec_xin           (cordic_vec_xin),
    .cordic_vec_yin           (cordic_vec_yin),
    .cordic_vec_angle_calc_en (cordic_vec_angle_calc_en),
    .cordic_vec_opvld         (cordic_vec_opvld),
    .cordic_rot_en            (cordic_rot_en),
    .cordic_rot_xin           (cordic_rot_xin),
    .cordic_rot_yin           (cordic_rot_yin),
    .cordic_rot_quad_in       (cordic_rot_quad_in),
    .cordic_rot_opvld         (cordic_rot_opvld),
    .vec_vld                  (vec_vld),
    .rot_vld                  (rot_vld),
    .busy                     (busy),
    .err_drop                 (err_drop)
  );

  // Scoreboard: every unit start must match the oldest operands the owner presented.
  always @(negedge clk) begin
    if (!rst && cordic_vec_en) begin
      checks++;
      if (vec_q.size() == 0) begin
        errors++;
        $display("FAIL vec_scoreboard: got unexpected issue x=%h y=%h, required no issue", cordic_vec_xin, cordic_vec_yin);
      end else begin
        vexp = vec_q.pop_front();
        if ({cordic_vec_xin, cordic_vec_yin} !== vexp) begin
          errors++;
          $display("FAIL vec_scoreboard: got %h required %h", {cordic_vec_xin, cordic_vec_yin}, vexp);
        end
      end
    end
    if (!rst && cordic_rot_en) begin
      checks++;
      if (rot_q.size() == 0) begin
        errors++;
        $display("FAIL rot_scoreboard: got unexpected issue x=%h y=%h, required no issue", cordic_rot_xin, cordic_rot_yin);
      end else begin
        rexp = rot_q.pop_front();
        if ({cordic_rot_quad_in, cordic_rot_xin, cordic_rot_yin} !== rexp) begin
          errors++;
          $display("FAIL rot_scoreboard: got %h required %h", {cordic_rot_quad_in, cordic_rot_xin, cordic_rot_yin}, rexp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_vec(input logic [15:0] x, input logic [15:0] y);
    vec_en  = 2'b01;
    vec_xin = {16'h0000, x};
    vec_yin = {16'h0000, y};
    vec_q.push_back({x, y});
  endtask

  task automatic issue_rot(input logic [15:0] x, input logic [15:0] y, input logic [1:0] q);
    rot_en      = 2'b01;
    rot_xin     = {16'h0000, x};
    rot_yin     = {16'h0000, y};
    rot_quad_in = {2'b00, q};
    rot_q.push_back({q, x, y});
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; vec_en = '0; rot_en = '0; vec_angle_calc_en = '0;
    vec_xin = '0; vec_yin = '0; rot_xin = '0; rot_yin = '0; rot_quad_in = '0;
    cordic_vec_opvld = 1'b0; cordic_rot_opvld = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b required 00", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (cordic_vec_en !== 1'b0 || cordic_rot_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b%b required 00", cordic_vec_en, cordic_rot_en); end
    checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL reset_err_drop: got %b required 0", err_drop); end
    checks++; if (cordic_vec_xin !== 16'h0 || cordic_rot_quad_in !== 2'b00) begin errors++; $display("FAIL reset_operands: got %h/%b required 0000/00", cordic_vec_xin, cordic_rot_quad_in); end
  endtask

  task automatic test_single();
    req = 2'b01;
    step();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b required 01", gnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b required 1", busy); end
    issue_vec(16'h0400, 16'h0300);
    step();
    vec_en = '0;
    checks++; if (cordic_vec_en !== 1'b1) begin errors++; $display("FAIL single_issue_en: got %b required 1", cordic_vec_en); end
    checks++; if (cordic_vec_xin !== 16'h0400 || cordic_vec_yin !== 16'h0300) begin errors++; $display("FAIL single_operands: got %h/%h required 0400/0300", cordic_vec_xin, cordic_vec_yin); end
    step();
    checks++; if (cordic_vec_en !== 1'b0) begin errors++; $display("FAIL single_en_pulse: got %b required 0", cordic_vec_en); end
    repeat (14) step();
    cordic_vec_opvld = 1'b1;
    #1;
    checks++; if (vec_vld !== 2'b01) begin errors++; $display("FAIL single_vec_vld: got %b required 01", vec_vld); end
    step();
    cordic_vec_opvld = 1'b0;
    req = 2'b00;
    step();
    checks++; if (busy !== 1'b0 || gnt !== 2'b00) begin errors++; $display("FAIL single_release: got busy=%b gnt=%b required 0/00", busy, gnt); end
    req = 2'b11;
    step();
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL single_ptr_advance: got %b required 10", gnt); end
    req = 2'b00;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_release: got %b required 0", busy); end
  endtask

  task automatic test_simultaneous();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 2'b11;
    step();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL simul_first: got %b required 01", gnt); end
    req = 2'b10;
    step();
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL simul_gap: got %b required 00", gnt); end
    step();
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL simul_second: got %b required 10", gnt); end
    req = 2'b01;
    step();
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL simul_gap2: got %b required 00", gnt); end
    req = 2'b11;
    step();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL simul_third: got %b required 01", gnt); end
    req = 2'b00;
    step();
  endtask

  task automatic test_drain();
    req = 2'b01;
    step();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL drain_gnt: got %b required 01", gnt); end
    issue_rot(16'h1111, 16'h2222, 2'd1); step();
    issue_rot(16'h3333, 16'h4444, 2'd2); step();
    issue_rot(16'h5555, 16'h6666, 2'd3); step();
    rot_en = '0;
    req = 2'b00;
    step();
    checks++; if (busy !== 1'b1 || gnt !== 2'b01) begin errors++; $display("FAIL drain_enter: got busy=%b gnt=%b required 1/01", busy, gnt); end
    for (int k = 0; k < 3; k++) begin
      cordic_rot_opvld = 1'b1;
      #1;
      checks++; if (rot_vld !== 2'b01) begin errors++; $display("FAIL drain_rot_vld%0d: got %b required 01", k, rot_vld); end
      step();
      cordic_rot_opvld = 1'b0;
      checks++; if (busy !== (k < 2)) begin errors++; $display("FAIL drain_busy%0d: got %b required %b", k, busy, (k < 2)); end
    end
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL drain_release: got %b required 00", gnt); end
  endtask

  task automatic test_intrusion();
    req = 2'b01;
    step();
    vec_en = 2'b10;
    vec_xin = {16'hBEEF, 16'h0000};
    step();
    vec_en = '0;
    checks++; if (cordic_vec_en !== 1'b0) begin errors++; $display("FAIL intr_en: got %b required 0", cordic_vec_en); end
    checks++; if (err_drop !== 1'b1) begin errors++; $display("FAIL intr_err: got %b required 1", err_drop); end
    checks++; if (vec_vld !== 2'b00) begin errors++; $display("FAIL intr_vec_vld: got %b required 00", vec_vld); end
    step();
    checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL intr_err_pulse: got %b required 0", err_drop); end
    issue_vec(16'h0123, 16'h0456);
    step();
    vec_en = '0;
    req = 2'b00;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL intr_drain_busy: got %b required 1", busy); end
    vec_en = 2'b01;
    step();
    vec_en = '0;
    checks++; if (err_drop !== 1'b1 || cordic_vec_en !== 1'b0) begin errors++; $display("FAIL intr_drain_drop: got err=%b en=%b required 1/0", err_drop, cordic_vec_en); end
    cordic_vec_opvld = 1'b1;
    step();
    cordic_vec_opvld = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL intr_release: got %b required 0", busy); end
  endtask

  task automatic test_same_cycle();
    req = 2'b01;
    step();
    issue_vec(16'h0111, 16'h0222);
    step();
    issue_vec(16'h0333, 16'h0444);
    cordic_vec_opvld = 1'b1;
    step();
    vec_en = '0;
    cordic_vec_opvld = 1'b0;
    req = 2'b00;
    step();
    checks++; if (busy !== 1'b1 || gnt !== 2'b01) begin errors++; $display("FAIL same_cycle_drain: got busy=%b gnt=%b required 1/01", busy, gnt); end
    cordic_vec_opvld = 1'b1;
    step();
    cordic_vec_opvld = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL same_cycle_release: got %b required 0", busy); end
  endtask

  task automatic test_saturation();
    req = 2'b01;
    step();
    for (int i = 0; i < 32; i++) begin
      issue_rot(16'(i), ~16'(i), 2'(i));
      step();
    end
    rot_en = '0;
    req = 2'b00;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sat_hold_max: got busy %b required 1", busy); end
    cordic_rot_opvld = 1'b1;
    repeat (30) step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sat_count30: got busy %b required 1", busy); end
    step();
    cordic_rot_opvld = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sat_count31: got busy %b required 0", busy); end
    req = 2'b01;
    step();
    cordic_rot_opvld = 1'b1;
    #1;
    checks++; if (rot_vld !== 2'b01) begin errors++; $display("FAIL underflow_route: got %b required 01", rot_vld); end
    step();
    cordic_rot_opvld = 1'b0;
    req = 2'b00;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL underflow_release: got busy %b required 0", busy); end
  endtask

  task automatic test_reset_mid();
    req = 2'b01;
    step();
    issue_rot(16'h000A, 16'h000B, 2'd0); step();
    issue_rot(16'h000C, 16'h000D, 2'd1); step();
    rot_en = '0;
    req = 2'b00;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_drain: got %b required 1", busy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (gnt !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_state: got gnt=%b busy=%b required 00/0", gnt, busy); end
    checks++; if (cordic_rot_xin !== 16'h0 || cordic_vec_xin !== 16'h0 || cordic_rot_en !== 1'b0 || err_drop !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: got rx=%h vx=%h en=%b err=%b required all 0", cordic_rot_xin, cordic_vec_xin, cordic_rot_en, err_drop); end
    cordic_rot_opvld = 1'b1;
    #1;
    checks++; if (rot_vld !== 2'b00) begin errors++; $display("FAIL rstmid_late_vld: got %b required 00", rot_vld); end
    step();
    cordic_rot_opvld = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got %b required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_drain();
    test_intrusion();
    test_same_cycle();
    test_saturation();
    test_reset_mid();
    step();
    checks++; if (vec_q.size() != 0 || rot_q.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d/%0d pending required 0/0", vec_q.size(), rot_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
